// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - opcode encoding and shift-amount width helper for the barrel shifter
package shifter_pkg;

   localparam logic [1:0] OP_LSL = 2'd0;
   localparam logic [1:0] OP_LSR = 2'd1;
   localparam logic [1:0] OP_ASR = 2'd2;
   localparam logic [1:0] OP_ROR = 2'd3;

   function automatic int shamt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one combinational barrel stage, shifts by 2**STAGE_IDX when enabled
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int STAGE_IDX = 0
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   input  logic             en,
   output logic [WIDTH-1:0] result
);

   localparam int S = 1 << STAGE_IDX;

   always_comb begin
      result = data;
      if (en) begin
         case (op)
            OP_LSL: result = data << S;
            OP_LSR: result = data >> S;
            OP_ASR: result = {{S{data[WIDTH-1]}}, data[WIDTH-1:S]};
            OP_ROR: result = {data[S-1:0], data[WIDTH-1:S]};
         endcase
      end
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined barrel shifter resolving one shamt bit per stage
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = shamt_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   localparam int LAST = SHAMT_W - 1;

   logic               adv;
   logic               zero_q;

   logic               st_valid  [SHAMT_W];
   logic [WIDTH-1:0]   st_data   [SHAMT_W];
   logic [SHAMT_W-1:0] st_shamt  [SHAMT_W];
   logic [1:0]         st_op     [SHAMT_W];

   logic               src_valid [SHAMT_W];
   logic [WIDTH-1:0]   src_data  [SHAMT_W];
   logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
   logic [1:0]         src_op    [SHAMT_W];
   logic [WIDTH-1:0]   shifted   [SHAMT_W];

   // The last stage register is the output register, so one stall signal freezes everything.
   assign adv      = !st_valid[LAST] | out_ready;
   assign in_ready = adv;

   always_comb begin
      src_valid[0] = in_valid & adv;
      src_data[0]  = in_data;
      src_shamt[0] = in_shamt;
      src_op[0]    = in_op;
      for (int k = 1; k < SHAMT_W; k++) begin
         src_valid[k] = st_valid[k-1];
         src_data[k]  = st_data[k-1];
         src_shamt[k] = st_shamt[k-1];
         src_op[k]    = st_op[k-1];
      end
   end

   generate
      for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
         shift_stage #(
            .WIDTH     (WIDTH),
            .STAGE_IDX (k)
         ) u_stage (
            .data   (src_data[k]),
            .op     (src_op[k]),
            .en     (src_shamt[k][0]),
            .result (shifted[k])
         );
      end
   endgenerate

   // Remaining shamt is shifted down each stage so every stage consumes bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SHAMT_W; k++) begin
            st_valid[k] <= 1'b0;
            st_data[k]  <= '0;
            st_shamt[k] <= '0;
            st_op[k]    <= OP_LSL;
         end
         zero_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < SHAMT_W; k++) begin
            st_valid[k] <= src_valid[k];
            st_data[k]  <= shifted[k];
            st_shamt[k] <= src_shamt[k] >> 1;
            st_op[k]    <= src_op[k];
         end
         zero_q <= src_valid[LAST] & (shifted[LAST] == '0);
      end
   end

   assign out_valid = st_valid[LAST];
   assign out_data  = st_data[LAST];
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for 8- and 32-bit shifter instances
module tb_pipelined_barrel_shifter;

   logic        clk = 1'b0;
   logic        rst;

   logic        v8, r8, ov8, or8, oz8;
   logic [7:0]  d8, od8;
   logic [2:0]  s8;
   logic [1:0]  o8;

   logic        v32, r32, ov32, or32, oz32;
   logic [31:0] d32, od32;
   logic [4:0]  s32;
   logic [1:0]  o32;

   int checks = 0;
   int errors = 0;
   int beats32 = 0;

   logic [63:0] q8  [$];
   logic [63:0] q32 [$];

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      logic [2:0] shamt;
      logic [7:0] exp;
   } vec_t;

   vec_t tab [15];

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst),
      .in_valid(v8), .in_ready(r8), .in_data(d8), .in_shamt(s8), .in_op(o8),
      .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_zero(oz8)
   );

   pipelined_barrel_shifter #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst),
      .in_valid(v32), .in_ready(r32), .in_data(d32), .in_shamt(s32), .in_op(o32),
      .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_zero(oz32)
   );

   // Reference: whole-word arithmetic on the full shift amount.
   function automatic logic [63:0] ref_shift(input int w, input logic [1:0] op,
                                             input logic [63:0] din, input int sh);
      logic [63:0] mask;
      logic [63:0] d;
      logic [63:0] r;
      mask = (64'd1 << w) - 64'd1;
      d    = din & mask;
      case (op)
         2'd0:    r = d << sh;
         2'd1:    r = d >> sh;
         2'd2:    r = d[w-1] ? ~((~d & mask) >> sh) : (d >> sh);
         default: r = (d >> sh) | (d << (w - sh));
      endcase
      return r & mask;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      logic [63:0] e;
      #1;
      if (ov8 && or8) begin
         if (q8.size() == 0) chk("sb8_unexpected_beat", 64'd1, 64'd0);
         else begin
            e = q8.pop_front();
            chk("sb8_data", {56'd0, od8}, e);
            chk("sb8_zero", {63'd0, oz8}, {63'd0, e == 64'd0});
         end
      end
      if (ov32 && or32) begin
         if (q32.size() == 0) chk("sb32_unexpected_beat", 64'd1, 64'd0);
         else begin
            e = q32.pop_front();
            chk("sb32_data", {32'd0, od32}, e);
            chk("sb32_zero", {63'd0, oz32}, {63'd0, e == 64'd0});
         end
      end
      if (v8 && r8) q8.push_back(ref_shift(8, o8, {56'd0, d8}, int'(s8)));
      if (v32 && r32) begin
         q32.push_back(ref_shift(32, o32, {32'd0, d32}, int'(s32)));
         beats32++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] held;
      int cyc;

      tab[0]  = '{2'd0, 8'h01, 3'd3, 8'h08};
      tab[1]  = '{2'd1, 8'h80, 3'd7, 8'h01};
      tab[2]  = '{2'd2, 8'h80, 3'd2, 8'hE0};
      tab[3]  = '{2'd3, 8'h81, 3'd1, 8'hC0};
      tab[4]  = '{2'd0, 8'hF0, 3'd4, 8'h00};
      tab[5]  = '{2'd0, 8'hA5, 3'd0, 8'hA5};
      tab[6]  = '{2'd1, 8'hA5, 3'd0, 8'hA5};
      tab[7]  = '{2'd2, 8'hA5, 3'd0, 8'hA5};
      tab[8]  = '{2'd3, 8'hA5, 3'd0, 8'hA5};
      tab[9]  = '{2'd0, 8'hFF, 3'd7, 8'h80};
      tab[10] = '{2'd2, 8'h80, 3'd7, 8'hFF};
      tab[11] = '{2'd2, 8'h7F, 3'd7, 8'h00};
      tab[12] = '{2'd3, 8'h01, 3'd7, 8'h02};
      tab[13] = '{2'd1, 8'h5A, 3'd4, 8'h05};
      tab[14] = '{2'd3, 8'h5A, 3'd4, 8'hA5};

      rst = 1'b1;
      v8 = 0; d8 = 0; s8 = 0; o8 = 0; or8 = 0;
      v32 = 0; d32 = 0; s32 = 0; o32 = 0; or32 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid8", {63'd0, ov8}, 64'd0);
      chk("reset_out_data8", {56'd0, od8}, 64'd0);
      chk("reset_out_zero8", {63'd0, oz8}, 64'd0);
      chk("reset_out_valid32", {63'd0, ov32}, 64'd0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready8", {63'd0, r8}, 64'd1);
      chk("reset_in_ready32", {63'd0, r32}, 64'd1);

      // Table vectors back-to-back: result i must appear exactly 3 cycles after its accept.
      or8 = 1'b1;
      for (int i = 0; i < 15 + 4; i++) begin
         if (i >= 3 && i - 3 < 15) begin
            chk($sformatf("tab%0d_valid", i - 3), {63'd0, ov8}, 64'd1);
            chk($sformatf("tab%0d_data", i - 3), {56'd0, od8}, {56'd0, tab[i-3].exp});
            chk($sformatf("tab%0d_zero", i - 3), {63'd0, oz8}, {63'd0, tab[i-3].exp == 8'h00});
         end else begin
            chk($sformatf("tab_idle%0d_valid", i), {63'd0, ov8}, 64'd0);
         end
         if (i < 15) begin
            v8 = 1'b1; o8 = tab[i].op; d8 = tab[i].data; s8 = tab[i].shamt;
            #1;
            chk("tab_in_ready", {63'd0, r8}, 64'd1);
         end else begin
            v8 = 1'b0;
         end
         @(posedge clk);
         #1;
      end

      // 32-bit ASR of the MSB by 31, latency 5.
      or32 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("w32_lat_valid_c%0d", i), {63'd0, ov32}, {63'd0, i == 5});
         if (i == 5) chk("w32_asr31_data", {32'd0, od32}, 64'hFFFF_FFFF);
         v32 = (i == 0); o32 = 2'd2; d32 = 32'h8000_0000; s32 = 5'd31;
         @(posedge clk);
         #1;
      end
      v32 = 1'b0;

      // Backpressure: fill with out_ready low, stall 5 cycles, then drain.
      or8 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         v8 = 1'b1; d8 = 8'($urandom); s8 = 3'($urandom); o8 = 2'($urandom);
         step();
      end
      chk("bp_fill_count", 64'(q8.size()), 64'd3);
      held = od8;
      for (int i = 0; i < 5; i++) begin
         v8 = 1'b1; d8 = 8'($urandom); s8 = 3'($urandom); o8 = 2'($urandom);
         step();
         chk("bp_in_ready", {63'd0, r8}, 64'd0);
         chk("bp_out_valid", {63'd0, ov8}, 64'd1);
         chk("bp_out_data_hold", {56'd0, od8}, {56'd0, held});
      end
      v8 = 1'b0;
      or8 = 1'b1;
      repeat (6) step();
      chk("bp_drained", 64'(q8.size()), 64'd0);
      chk("bp_idle_valid", {63'd0, ov8}, 64'd0);

      // Reset with three beats in flight.
      or8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v8 = 1'b1; d8 = 8'h3C + 8'(i); s8 = 3'd1; o8 = 2'd0;
         @(posedge clk);
         #1;
      end
      v8 = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {63'd0, ov8}, 64'd0);
      chk("midrst_out_data", {56'd0, od8}, 64'd0);
      chk("midrst_out_zero", {63'd0, oz8}, 64'd0);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", {63'd0, r8}, 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("midrst_no_stale", {63'd0, ov8}, 64'd0);
      end

      // Random traffic on both instances against the reference model.
      cyc = 0;
      while (beats32 < 10000 && cyc < 40000) begin
         v8   = ($urandom_range(0, 3) != 0);
         d8   = 8'($urandom);
         s8   = 3'($urandom);
         o8   = 2'($urandom);
         or8  = ($urandom_range(0, 3) != 0);
         v32  = ($urandom_range(0, 3) != 0);
         d32  = $urandom;
         s32  = 5'($urandom);
         o32  = 2'($urandom);
         or32 = ($urandom_range(0, 3) != 0);
         step();
         cyc++;
      end
      if (beats32 < 10000) chk("random_beat_budget", 64'(beats32), 64'd10000);
      v8 = 1'b0; v32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
      repeat (8) step();
      chk("random_drained8", 64'(q8.size()), 64'd0);
      chk("random_drained32", 64'(q32.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
